hex_scan_display: RTL and testbench

- Multi-digit, time-multiplexed hex display driver: holds an N-digit hex value and scans it onto one shared 7-segment bus plus per-digit anode enables.
- Each digit uses the standard 0-F glyph set; adds a refresh prescaler, a load-qualified shadow register, per-digit blanking, leading-zero suppression and decimal points.
- Sits between datapath registers and the board's segment/anode pins.

---
 rtl/hex_scan_display.sv | 141 ++++++++++++++
 tb/tb_hex_scan_display.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/hex_scan_display.sv
// Time-multiplexed N-digit hex display driver: shadowed value/dp/mask, refresh prescaler,
// leading-zero suppression and a one-cycle dark gap between digit slots.
module hex_scan_display #(
   parameter int unsigned NUM_DIGITS     = 4,
   parameter int unsigned REFRESH_DIV    = 50000,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          AN_ACTIVE_LOW  = 1'b1,
   localparam int unsigned IdxW          = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic                    load,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_mask,
   input  logic                    blank_lz,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [IdxW-1:0]         digit_idx
);

   localparam int unsigned PreW = $clog2(REFRESH_DIV);
   localparam logic [PreW-1:0] LastPre = PreW'(REFRESH_DIV - 1);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);

   logic [PreW-1:0]         pre_q, pre_d;
   logic [IdxW-1:0]         idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] val_q, val_d;
   logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
   logic [NUM_DIGITS-1:0]   mask_q, mask_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;

   logic                    tick;
   logic                    zero_run;
   logic [NUM_DIGITS-1:0]   upper_zero;
   logic [3:0]              nib;
   logic                    sel_dp, sel_mask, sel_lz, dark;
   logic [NUM_DIGITS-1:0]   an_raw;
   logic [6:0]              seg_raw;
   logic                    dp_raw;

   function automatic logic [6:0] glyph(input logic [3:0] n);
      logic [6:0] g;
      g = 7'h00;
      unique case (n)
         4'h0: g = 7'h3F;
         4'h1: g = 7'h06;
         4'h2: g = 7'h5B;
         4'h3: g = 7'h4F;
         4'h4: g = 7'h66;
         4'h5: g = 7'h6D;
         4'h6: g = 7'h7D;
         4'h7: g = 7'h07;
         4'h8: g = 7'h7F;
         4'h9: g = 7'h67;
         4'hA: g = 7'h77;
         4'hB: g = 7'h7C;
         4'hC: g = 7'h39;
         4'hD: g = 7'h5E;
         4'hE: g = 7'h79;
         4'hF: g = 7'h71;
      endcase
      return g;
   endfunction

   always_comb begin
      tick  = (pre_q == LastPre);
      pre_d = tick ? '0 : pre_q + 1'b1;
      idx_d = idx_q;
      if (tick) begin
         idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
      end

      val_d   = load ? value      : val_q;
      dp_sh_d = load ? dp_in      : dp_sh_q;
      mask_d  = load ? blank_mask : mask_q;

      // upper_zero[k]: every shadow nibble from k up to the top digit is zero
      zero_run   = 1'b1;
      upper_zero = '0;
      for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
         zero_run      = zero_run & (val_q[4*k +: 4] == 4'h0);
         upper_zero[k] = zero_run;
      end

      nib      = 4'h0;
      sel_dp   = 1'b0;
      sel_mask = 1'b0;
      sel_lz   = 1'b0;
      an_raw   = '0;
      for (int k = 0; k < int'(NUM_DIGITS); k++) begin
         if (idx_q == IdxW'(k)) begin
            nib       = val_q[4*k +: 4];
            sel_dp    = dp_sh_q[k];
            sel_mask  = mask_q[k];
            sel_lz    = (k != 0) && upper_zero[k];
            an_raw[k] = !tick;
         end
      end

      // The slot following a tick is driven fully dark to avoid ghosting.
      dark    = sel_mask | (blank_lz & sel_lz);
      seg_raw = (tick || dark) ? 7'h00 : glyph(nib);
      dp_raw  = !tick && !dark && sel_dp;

      seg_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
      dp_d  = SEG_ACTIVE_LOW ? ~dp_raw  : dp_raw;
      an_d  = AN_ACTIVE_LOW  ? ~an_raw  : an_raw;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_q   <= '0;
         idx_q   <= '0;
         val_q   <= '0;
         dp_sh_q <= '0;
         mask_q  <= '0;
         seg_q   <= {7{SEG_ACTIVE_LOW}};
         dp_q    <= SEG_ACTIVE_LOW;
         an_q    <= {NUM_DIGITS{AN_ACTIVE_LOW}};
      end else begin
         pre_q   <= pre_d;
         idx_q   <= idx_d;
         val_q   <= val_d;
         dp_sh_q <= dp_sh_d;
         mask_q  <= mask_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         an_q    <= an_d;
      end
   end

   assign seg       = seg_q;
   assign dp        = dp_q;
   assign an        = an_q;
   assign digit_idx = idx_q;

endmodule

// File: tb/tb_hex_scan_display.sv
// Bench for hex_scan_display: directed and random loads checked every cycle against a
// time-based reference model (slot = cycle / REFRESH_DIV).
module tb_hex_scan_display;

   localparam int N   = 4;
   localparam int DIV = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [15:0]   value;
   logic          load;
   logic [3:0]    dp_in;
   logic [3:0]    blank_mask;
   logic          blank_lz;
   logic [6:0]    seg;
   logic          dp;
   logic [3:0]    an;
   logic [1:0]    digit_idx;

   hex_scan_display #(
      .NUM_DIGITS    (N),
      .REFRESH_DIV   (DIV),
      .SEG_ACTIVE_LOW(1'b1),
      .AN_ACTIVE_LOW (1'b1)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .value     (value),
      .load      (load),
      .dp_in     (dp_in),
      .blank_mask(blank_mask),
      .blank_lz  (blank_lz),
      .seg       (seg),
      .dp        (dp),
      .an        (an),
      .digit_idx (digit_idx)
   );

   always #5 clk = ~clk;

   logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   logic [15:0] m_val;
   logic [3:0]  m_dp, m_mask;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp)
      else begin
         bad++;
         $error("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   // One clock: drive inputs, predict the registered outputs from the elapsed-cycle count.
   task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d,
                       input logic [3:0] m, input logic lz);
      int p, k, hi;
      logic is_dark;
      logic [6:0] e_seg;
      logic e_dp;
      logic [3:0] e_an;
      load = ld; value = v; dp_in = d; blank_mask = m; blank_lz = lz;
      p  = cyc % DIV;
      k  = (cyc / DIV) % N;
      hi = -1;
      for (int i = 0; i < N; i++) if (m_val[4*i +: 4] != 4'h0) hi = i;
      is_dark = m_mask[k] || (lz && k > 0 && k > hi);
      if (p == DIV - 1) begin
         e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
      end else begin
         e_an  = ~(4'b0001 << k);
         e_seg = is_dark ? 7'h7F : ~glyph_tab[m_val[4*k +: 4]];
         e_dp  = is_dark ? 1'b1 : ~m_dp[k];
      end
      @(posedge clk);
      if (ld) begin m_val = v; m_dp = d; m_mask = m; end
      cyc++;
      #1;
      chk("seg", 32'(seg), 32'(e_seg));
      chk("dp", 32'(dp), 32'(e_dp));
      chk("an", 32'(an), 32'(e_an));
      chk("digit_idx", 32'(digit_idx), 32'((cyc / DIV) % N));
      load = 1'b0;
   endtask

   task automatic run(input int n, input logic lz);
      for (int i = 0; i < n; i++) step(1'b0, 16'(($urandom)), 4'h0, 4'h0, lz);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      chk("rst_an", 32'(an), 32'h0000000F);
      chk("rst_seg", 32'(seg), 32'h0000007F);
      chk("rst_dp", 32'(dp), 32'h00000001);
      chk("rst_idx", 32'(digit_idx), 32'h00000000);
      @(negedge clk);
      reset = 1'b0;
      cyc = 0; m_val = '0; m_dp = '0; m_mask = '0;
   endtask

   initial begin
      reset = 1'b1; load = 1'b0; value = '0; dp_in = '0; blank_mask = '0; blank_lz = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // Scan order with 1234, lz off
      step(1'b1, 16'h1234, 4'h0, 4'h0, 1'b0);
      run(2 * N * DIV, 1'b0);

      // Glyph sweep, FFFF down to 0000
      for (int g = 15; g >= 0; g--) begin
         step(1'b1, {4{4'(g)}}, 4'h0, 4'h0, 1'b0);
         run(N * DIV + 1, 1'b0);
      end

      // Leading-zero suppression
      step(1'b1, 16'h0050, 4'h0, 4'h0, 1'b1);
      run(N * DIV + 2, 1'b1);
      step(1'b1, 16'h0000, 4'h0, 4'h0, 1'b1);
      run(N * DIV + 2, 1'b1);

      // Mask and dp
      step(1'b1, 16'h1234, 4'b0010, 4'b0100, 1'b0);
      run(N * DIV + 2, 1'b0);

      // Load on the terminal prescaler cycle
      while (cyc % DIV != DIV - 1) step(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
      step(1'b1, 16'hABCD, 4'h0, 4'h0, 1'b0);
      run(N * DIV + 2, 1'b0);

      // Reset mid-slot, then scanning restarts from digit 0
      run(5, 1'b0);
      do_reset();
      run(N * DIV, 1'b0);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 3) == 0), 16'($urandom),
              4'($urandom), (($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0),
              1'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
